// File: rtl/load_memory_decoder_pkg.sv
// load_memory_decoder_pkg: load type and FSM state encodings shared by the load path.
package load_memory_decoder_pkg;
    typedef enum logic [2:0] {LOAD_B, LOAD_H, LOAD_W, LOAD_BU, LOAD_HU} load_type_t;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
endpackage

// File: rtl/load_memory_decoder.sv
// load_memory_decoder: combinational lane select, alignment check and extension of a load word.
module load_memory_decoder
    import load_memory_decoder_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  offset,
    input  logic [31:0] raw,
    output logic [3:0]  sel,
    output logic [31:0] data,
    output logic        misaligned
);
    logic        is_b;
    logic        is_h;
    logic [15:0] lane;
    always_comb begin
        is_b = load_type == LOAD_B || load_type == LOAD_BU;
        is_h = load_type == LOAD_H || load_type == LOAD_HU;
        // shifting instead of part-selecting keeps offset 3 halves in range
        lane = 16'(raw >> {offset, 3'b000});
        misaligned = is_h ? offset == 2'd3 : !is_b && offset != 2'd0;
        sel = is_b ? 4'b0001 << offset : is_h ? 4'b0011 << offset : 4'b1111;
        data = load_type == LOAD_B  ? {{24{lane[7]}}, lane[7:0]} :
               load_type == LOAD_BU ? {24'b0, lane[7:0]} :
               load_type == LOAD_H  ? {{16{lane[15]}}, lane} :
               load_type == LOAD_HU ? {16'b0, lane} : raw;
    end
endmodule

// File: rtl/load_memory_unit.sv
// load_memory_unit: sequential Wishbone-classic load path with alignment and bus error reporting.
// Optional bus timeout is enabled by defining LOAD_MEMORY_UNIT_TIMEOUT_EN.
module load_memory_unit
    import load_memory_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        misaligned_exception,
    output logic        access_fault,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    state_t      state;
    state_t      state_next;
    logic [2:0]  type_q;
    logic [1:0]  off_q;
    logic [3:0]  dec_sel;
    logic [31:0] dec_data;
    logic        dec_mis;
    logic        accept;
    logic        done;
    logic        timeout;

    // one decoder serves both the request check in IDLE and the data decode in BUS
    load_memory_decoder u_dec (
        .load_type  (state == IDLE ? req_type : type_q),
        .offset     (state == IDLE ? req_addr[1:0] : off_q),
        .raw        (wb_dat_i),
        .sel        (dec_sel),
        .data       (dec_data),
        .misaligned (dec_mis)
    );

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign accept     = req_valid && state == IDLE;
    assign done       = state == BUS && (wb_ack_i || wb_err_i || timeout);

`ifdef LOAD_MEMORY_UNIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= state == BUS ? cnt + 1'b1 : '0;
    end
    assign timeout = state == BUS && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        state_next = state == IDLE ? (accept ? (dec_mis ? RESP : BUS) : IDLE) :
                     state == BUS  ? (done ? RESP : BUS) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q               <= '0;
            off_q                <= '0;
            wb_cyc_o             <= 1'b0;
            wb_stb_o             <= 1'b0;
            wb_adr_o             <= '0;
            wb_sel_o             <= '0;
            resp_data            <= '0;
            misaligned_exception <= 1'b0;
            access_fault         <= 1'b0;
        end else if (accept) begin
            type_q <= req_type;
            off_q  <= req_addr[1:0];
            if (dec_mis) begin
                misaligned_exception <= 1'b1;
                access_fault         <= 1'b0;
                resp_data            <= '0;
            end else begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_adr_o <= {req_addr[31:2], 2'b00};
                wb_sel_o <= dec_sel;
            end
        end else if (done) begin
            // without ack the termination was err or timeout; err also wins over a same-cycle ack
            wb_cyc_o             <= 1'b0;
            wb_stb_o             <= 1'b0;
            misaligned_exception <= 1'b0;
            access_fault         <= wb_err_i || !wb_ack_i;
            resp_data            <= wb_ack_i && !wb_err_i ? dec_data : '0;
        end
    end
endmodule
